// File: rtl/piano_pkg.sv
// Shared key ordering, note numbering and debounce timing defaults for the piano front end.
// Bit 6 of the key vector is note 1, bit 0 is note 7.
package piano_pkg;

    localparam int CLK_HZ                 = 50_000_000;
    localparam int NUM_KEYS               = 7;
    localparam int DEFAULT_TICK_CYCLES    = 250_000;
    localparam int DEFAULT_STABLE_SAMPLES = 4;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_1    = 3'd1,
        NOTE_2    = 3'd2,
        NOTE_3    = 3'd3,
        NOTE_4    = 3'd4,
        NOTE_5    = 3'd5,
        NOTE_6    = 3'd6,
        NOTE_7    = 3'd7
    } note_e;

    // Multi-press or no press both decode to NOTE_NONE so the display blanks.
    function automatic logic [2:0] onehot_to_code(input logic [NUM_KEYS-1:0] btn);
        logic [2:0] code;
        int         hits;
        code = NOTE_NONE;
        hits = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (btn[i]) begin
                hits = hits + 1;
                code = 3'(NUM_KEYS - i);
            end
        end
        return (hits == 1) ? code : NOTE_NONE;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One button: 2-FF synchroniser, polarity fix, sample history and accepted level.
// The accepted level only moves on a tick, when every history bit agrees.
module key_debounce_cell
    import piano_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_key_raw,
    output logic o_btn
);

    logic                      r_sync1;
    logic                      r_sync2;
    logic [STABLE_SAMPLES-1:0] r_hist;
    logic                      r_btn;
    logic                      w_sync_key;
    logic [STABLE_SAMPLES-1:0] w_hist_next;

    assign w_sync_key  = r_sync2 ^ ACTIVE_LOW;
    assign w_hist_next = {r_hist[STABLE_SAMPLES-2:0], w_sync_key};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Synchronisers reset to the raw "released" level so no false press follows reset.
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
            r_hist  <= '0;
            r_btn   <= 1'b0;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_hist <= w_hist_next;
                if ((&w_hist_next) && !r_btn) begin
                    r_btn <= 1'b1;
                end else if (!(|w_hist_next) && r_btn) begin
                    r_btn <= 1'b0;
                end
            end
        end
    end

    assign o_btn = r_btn;

endmodule

// File: rtl/key_scan_debounce.sv
// Seven-key debounce front end: shared sample tick, per-key cells, note decode
// and registered press/release strobes.
module key_scan_debounce
    import piano_pkg::*;
#(
    parameter int TICK_CYCLES    = DEFAULT_TICK_CYCLES,
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    output logic [NUM_KEYS-1:0] o_btn,
    output logic                o_key_valid,
    output logic [2:0]          o_key_code,
    output logic                o_key_press,
    output logic                o_key_release
);

    localparam int                TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_btn;
    logic [2:0]          w_key_code;
    logic [2:0]          r_prev_code;
    logic                r_key_press;
    logic                r_key_release;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cell
        key_debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_cell (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_key_raw (i_key_raw[g]),
            .o_btn     (w_btn[g])
        );
    end

    assign w_key_code = onehot_to_code(w_btn);

    // A one-key to another-key switch is a press only; release fires only when the code drops to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_code   <= NOTE_NONE;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_prev_code   <= w_key_code;
            r_key_press   <= (w_key_code != r_prev_code) && (w_key_code != NOTE_NONE);
            r_key_release <= (w_key_code != r_prev_code) && (w_key_code == NOTE_NONE);
        end
    end

    assign o_btn         = w_btn;
    assign o_key_code    = w_key_code;
    assign o_key_valid   = (w_key_code != NOTE_NONE);
    assign o_key_press   = r_key_press;
    assign o_key_release = r_key_release;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with TICK_CYCLES=4, STABLE_SAMPLES=3, active-low keys.
module tb_key_scan_debounce;

    logic       clk;
    logic       rst;
    logic [6:0] key_raw;
    logic [6:0] btn;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_press;
    logic       key_release;

    int checks  = 0;
    int errors  = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_both  = 0;

    key_scan_debounce #(
        .TICK_CYCLES    (4),
        .STABLE_SAMPLES (3),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_raw     (key_raw),
        .o_btn         (btn),
        .o_key_valid   (key_valid),
        .o_key_code    (key_code),
        .o_key_press   (key_press),
        .o_key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_press)                n_press <= n_press + 1;
        if (key_release)              n_rel   <= n_rel + 1;
        if (key_press && key_release) n_both  <= n_both + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_btn(input logic [6:0] want, output int n);
        n = 0;
        while (btn !== want && n < 40) begin
            step();
            n++;
        end
    endtask

    int n;
    int p0, r0;
    int bounce_bad;

    initial begin
        // 1: reset
        rst     = 1'b1;
        key_raw = 7'h7F;
        repeat (3) step();
        chk("rst_btn",     32'(btn),         32'h0);
        chk("rst_code",    32'(key_code),    32'h0);
        chk("rst_valid",   32'(key_valid),   32'h0);
        chk("rst_press",   32'(key_press),   32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        rst = 1'b0;
        n = 0;
        while (!dut.w_tick && n < 10) begin
            step();
            n++;
        end
        chk("first_tick_cycle", 32'(n), 32'd3);

        // 2: clean press and release of note 1
        key_raw = 7'b0111111;
        wait_btn(7'b1000000, n);
        chk("n1_btn",        32'(btn), 32'h40);
        chk("n1_latency_ok", 32'(n >= 9 && n <= 15), 32'h1);
        chk("n1_code",       32'(key_code),  32'd1);
        chk("n1_valid",      32'(key_valid), 32'h1);
        chk("n1_press_lag0", 32'(key_press), 32'h0);
        step();
        chk("n1_press_lag1", 32'(key_press), 32'h1);
        step();
        chk("n1_press_lag2", 32'(key_press), 32'h0);
        key_raw = 7'h7F;
        wait_btn(7'b0000000, n);
        chk("n1_rel_btn", 32'(btn), 32'h0);
        step();
        chk("n1_rel_pulse", 32'(key_release), 32'h1);
        repeat (3) step();
        chk("n1_press_count", 32'(n_press), 32'd1);
        chk("n1_rel_count",   32'(n_rel),   32'd1);

        // 3: bounce on note 5, then hold
        p0 = n_press;
        r0 = n_rel;
        bounce_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) key_raw[2] = ~key_raw[2];
            step();
            if (btn !== 7'h00) bounce_bad++;
        end
        chk("bounce_btn_quiet", 32'(bounce_bad), 32'd0);
        chk("bounce_no_press",  32'(n_press - p0), 32'd0);
        chk("bounce_no_rel",    32'(n_rel - r0),   32'd0);
        key_raw = 7'b1111011;
        wait_btn(7'b0000100, n);
        chk("n5_btn",  32'(btn),      32'h04);
        chk("n5_code", 32'(key_code), 32'd5);
        repeat (3) step();
        chk("n5_press_count", 32'(n_press - p0), 32'd1);
        key_raw = 7'h7F;
        wait_btn(7'b0000000, n);
        repeat (3) step();

        // 4: multi-press of notes 3 and 4
        key_raw = 7'b1101111;
        wait_btn(7'b0010000, n);
        chk("n3_code", 32'(key_code), 32'd3);
        repeat (3) step();
        p0 = n_press;
        r0 = n_rel;
        key_raw = 7'b1100111;
        wait_btn(7'b0011000, n);
        chk("multi_btn",   32'(btn),       32'h18);
        chk("multi_valid", 32'(key_valid), 32'h0);
        chk("multi_code",  32'(key_code),  32'd0);
        repeat (3) step();
        chk("multi_rel_count",   32'(n_rel - r0),   32'd1);
        chk("multi_press_count", 32'(n_press - p0), 32'd0);
        key_raw = 7'b1110111;
        wait_btn(7'b0001000, n);
        chk("n4_code", 32'(key_code), 32'd4);
        repeat (3) step();
        chk("n4_press_count", 32'(n_press - p0), 32'd1);
        key_raw = 7'h7F;
        wait_btn(7'b0000000, n);
        repeat (3) step();

        // 5: note 3 straight to note 5 on one tick
        key_raw = 7'b1101111;
        wait_btn(7'b0010000, n);
        repeat (3) step();
        p0 = n_press;
        r0 = n_rel;
        key_raw = 7'b1111011;
        n = 0;
        while (btn === 7'b0010000 && n < 40) begin
            step();
            n++;
        end
        chk("switch_btn",  32'(btn),      32'h04);
        chk("switch_code", 32'(key_code), 32'd5);
        repeat (3) step();
        chk("switch_press_count", 32'(n_press - p0), 32'd1);
        chk("switch_rel_count",   32'(n_rel - r0),   32'd0);
        key_raw = 7'h7F;
        wait_btn(7'b0000000, n);
        repeat (3) step();

        // 6: reset while note 7 is held
        key_raw = 7'b1111110;
        wait_btn(7'b0000001, n);
        chk("n7_code", 32'(key_code), 32'd7);
        repeat (3) step();
        p0 = n_press;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_btn",   32'(btn),       32'h0);
        chk("midrst_code",  32'(key_code),  32'h0);
        chk("midrst_press", 32'(key_press), 32'h0);
        wait_btn(7'b0000001, n);
        chk("n7_reaccept_btn",     32'(btn), 32'h01);
        chk("n7_reaccept_latency", 32'(n >= 9 && n <= 15), 32'h1);
        repeat (3) step();
        chk("n7_reaccept_press", 32'(n_press - p0), 32'd1);
        chk("strobes_exclusive", 32'(n_both),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_scan_debounce.md
Name: key_scan_debounce

Overview:
- Front end for the seven note buttons; produces the `btn[6:0]` one-hot vector consumed by the 7-segment decoder and the tone generator.
- Synchronises raw board buttons, debounces each one, and presents a clean active-high vector.
- Also provides a decoded note number (1..7) and single-cycle press/release strobes for downstream sequencing.

Parameters:
- TICK_CYCLES, 250000, clk cycles between debounce samples (5 ms at 50 MHz); minimum 2.
- STABLE_SAMPLES, 4, consecutive equal samples needed to accept a new level (20 ms); range 2..8.
- ACTIVE_LOW, 1, 1 means a pressed raw key reads 0.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- key_raw, input, 7, asynchronous raw buttons; bit 6 = note 1 ... bit 0 = note 7.
- btn, output, 7, debounced, active-high, same bit order as key_raw; drives the seg decoder.
- key_valid, output, 1, exactly one bit of btn set.
- key_code, output, 3, note number 1..7 when key_valid, else 0.
- key_press, output, 1, one-cycle strobe when key_code changes to a nonzero value.
- key_release, output, 1, one-cycle strobe when key_code changes from nonzero to 0.

Behaviour:
- Clock and reset: single clock domain `clk`; reset is synchronous and active-high on `rst`.
- Input conditioning:
  - Each key_raw bit passes through a 2-FF synchroniser.
  - It is then inverted when ACTIVE_LOW=1.
  - Result: sync_key[i], 1 = pressed.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick is high for exactly the one cycle where count == TICK_CYCLES-1.
  - The counter is shared by all keys.
- Per-key cell:
  - On tick, sync_key[i] shifts into an STABLE_SAMPLES-bit history register.
  - If all history bits equal v and v != btn[i], btn[i] <= v on the same clock edge that records the sample.
  - No update between ticks.
- Latency from raw edge to btn edge, for stable input:
  - Minimum (STABLE_SAMPLES-1)*TICK_CYCLES+3 cycles.
  - Maximum STABLE_SAMPLES*TICK_CYCLES+3 cycles.
  - All keys update on the same tick edge.
- Bounce: any disagreeing sample within the history blocks the update. A glitch shorter than one tick period that is not sampled is ignored.
- key_valid and key_code:
  - Derived combinationally from the btn register; no added latency.
  - Zero keys set, or two or more keys set, gives key_valid=0 and key_code=0. This matches the decoder blanking on multi-press.
- Strobes:
  - prev_code is a register of key_code.
  - key_press = (key_code != prev_code) && key_code != 0, registered, so it rises 1 cycle after btn changes.
  - key_release = (key_code != prev_code) && key_code == 0, registered.
  - A direct change from one single key to another (e.g. 3 -> 5 on one tick) gives key_press only, with no key_release.
  - The strobes are never high simultaneously.
- Reset values:
  - btn=0, key_valid=0, key_code=0, key_press=0, key_release=0.
  - Tick counter = 0; histories = all released; synchronisers = released; prev_code=0.
- Reset mid-operation: all state clears on the next edge with rst high. A key still held after rst falls is re-accepted after the normal latency, producing a fresh key_press.
- Width rules:
  - Tick counter width = clog2(TICK_CYCLES).
  - History width = STABLE_SAMPLES.
  - key_code is 3 bits. Encoding: btn bit 6 -> 1, bit 5 -> 2, ..., bit 0 -> 7.

Decomposition:
- Shared package `piano_pkg`:
  - CLK_HZ = 50_000_000.
  - NUM_KEYS = 7.
  - Note-number constants NOTE_NONE = 0 .. NOTE_7 = 7.
  - Default debounce timing constants.
  - The seg decoder and tone generator import the same key ordering from here.
- One sub-module: `key_debounce_cell`, instantiated 7×. It holds the synchroniser, polarity fix, history register and accepted level, with tick as an input.
- Top level holds the tick counter, one-hot-to-code logic and the strobe registers.

Test Plan (TICK_CYCLES=4, STABLE_SAMPLES=3, ACTIVE_LOW=1 unless noted):
1. Reset: rst high 3 cycles with key_raw=7'h7F. Required: btn=0, key_code=0, key_valid=0, no strobes; tick first seen at cycle 3 after rst falls.
2. Clean press of note 1: key_raw=7'b0111111 held.
   - btn=7'b1000000 within 9..15 cycles, key_code=1, key_valid=1.
   - key_press is high exactly 1 cycle, one cycle after btn changes.
   - Releasing gives btn=0 and one key_release pulse.
3. Bounce rejection: toggle key_raw bit 2 (note 5) every 3 cycles for 40 cycles, then hold pressed.
   - btn stays 0 throughout the bouncing; no strobes.
   - Then btn=7'b0000100, key_code=5, one key_press.
4. Multi-press: note 3 held and accepted, then note 4 also pressed.
   - btn=7'b0011000, key_valid=0, key_code=0, one key_release.
   - Releasing note 3 gives key_code=4 and one key_press.
5. Direct switch: note 3 to note 5 arranged to land on the same tick. Required: key_code goes 3 -> 5, one key_press, no key_release.
6. Reset mid-hold: note 7 accepted, rst pulsed 1 cycle with the key still held.
   - btn=0 the cycle after reset.
   - Re-accepted to 7'b0000001 after 9..15 cycles, with a new key_press.
